uart_fifo_bridge: RTL and testbench

- Buffering stage between the Z80-side port decoder and the uart block; owns the uart's txdata/txbegin and data_read inputs, consumes its txbusy/rxdata/rxrecv outputs.
- Holds a TX FIFO that feeds uart_tx byte by byte, and an RX FIFO that drains uart_rx.
- The CPU gets first-word-fall-through reads and fire-and-forget writes; RX backpressure is applied by withholding data_read, which keeps the uart's rts deasserted.

---
 rtl/uart_fifo_bridge.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge
//   Buffering stage between the Z80-side port decoder and the uart block.
//   A TX FIFO feeds the uart transmitter one byte at a time; an RX FIFO
//   drains the uart receiver. The CPU side sees first-word-fall-through
//   reads and fire-and-forget writes. RX backpressure is applied by
//   withholding data_read, which keeps the uart's rts deasserted.
//
// Ports
//   clk_bus      bus clock, all logic on its rising edge
//   rst_n        asynchronous active-low reset
//   fifo_clr     one-cycle strobe: flush both FIFOs, clear tx_drop
//   cpu_wdata    byte to transmit
//   cpu_wr       one-cycle strobe: push cpu_wdata into the TX FIFO
//   cpu_rd       one-cycle strobe: pop the RX FIFO head
//   cpu_rdata    RX FIFO head, 8'h00 when empty
//   rx_avail     RX FIFO not empty
//   rx_full      RX FIFO full
//   tx_full      TX FIFO full
//   tx_empty     TX FIFO empty and no byte in flight
//   tx_drop      sticky: a cpu_wr was lost because TX was full
//   rx_count     RX occupancy, 0..DEPTH
//   txdata       to uart.txdata (registered)
//   txbegin      to uart.txbegin (registered)
//   txbusy       from uart.txbusy
//   rxdata       from uart.rxdata
//   rxrecv       from uart.rxrecv
//   data_read    to uart.data_read (registered one-cycle pulse)
//   tx_state_dbg current TX FSM state (debug)
//   rx_state_dbg current RX FSM state (debug)
//
// Handshakes
//   CPU side: cpu_wr/cpu_rd are single-cycle strobes with no stall. A write
//   is taken when the TX FIFO has room (or frees a slot that same cycle),
//   otherwise it is dropped and flagged; a read pops only when rx_avail=1.
//   uart TX: txbegin is a one-cycle valid pulse issued only while txbusy=0;
//   txbusy=1 means the uart owns the byte. uart RX: rxrecv is valid and is
//   held until the uart sees data_read; data_read is the one-cycle accept.

module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_bus,
    input  logic                  rst_n,
    input  logic                  fifo_clr,
    input  logic [7:0]            cpu_wdata,
    input  logic                  cpu_wr,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_rdata,
    output logic                  rx_avail,
    output logic                  rx_full,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic                  tx_drop,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic [7:0]            txdata,
    output logic                  txbegin,
    input  logic                  txbusy,
    input  logic [7:0]            rxdata,
    input  logic                  rxrecv,
    output logic                  data_read,
    output logic [1:0]            tx_state_dbg,
    output logic [1:0]            rx_state_dbg
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        T_IDLE   = 2'd0,
        T_LAUNCH = 2'd1,
        T_WAIT   = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_DROP = 2'd2
    } rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [7:0]            tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] tx_wr_ptr;
    logic [DEPTH_LOG2-1:0] tx_rd_ptr;
    logic [DEPTH_LOG2:0]   tx_cnt;
    logic                  tx_is_full;
    logic                  tx_is_empty;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  tx_drop_set;
    tx_state_t             tx_state;
    tx_state_t             tx_next;
    logic                  txbegin_next;
    logic [7:0]            txdata_next;

    assign tx_is_full  = (tx_cnt == CNT_FULL);
    assign tx_is_empty = (tx_cnt == '0);

    // A write on a full FIFO still lands if the FSM frees the head slot in
    // the same cycle.
    assign tx_push     = cpu_wr && !fifo_clr && (!tx_is_full || tx_pop);
    assign tx_drop_set = cpu_wr && !fifo_clr && tx_is_full && !tx_pop;

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
            tx_drop   <= 1'b0;
        end else if (fifo_clr) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_cnt    <= '0;
            tx_drop   <= 1'b0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + CNT_ONE;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - CNT_ONE;
            if (tx_drop_set) tx_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= cpu_wdata;
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            txbegin  <= 1'b0;
            txdata   <= 8'h00;
        end else begin
            tx_state <= tx_next;
            txbegin  <= txbegin_next;
            txdata   <= txdata_next;
        end
    end

    // Launch is held off during a flush so the flushed head is never sent;
    // a byte already in T_LAUNCH/T_WAIT is left to finish.
    always_comb begin
        tx_next      = tx_state;
        tx_pop       = 1'b0;
        txbegin_next = 1'b0;
        txdata_next  = txdata;
        case (tx_state)
            T_IDLE: begin
                if (!tx_is_empty && !txbusy && !fifo_clr) begin
                    tx_pop       = 1'b1;
                    txbegin_next = 1'b1;
                    txdata_next  = tx_mem[tx_rd_ptr];
                    tx_next      = T_LAUNCH;
                end
            end
            T_LAUNCH: tx_next = T_WAIT;
            T_WAIT: begin
                if (!txbusy) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    assign tx_full      = tx_is_full;
    assign tx_empty     = tx_is_empty && (tx_state == T_IDLE);
    assign tx_state_dbg = tx_state;

    // ---------------- RX FIFO ----------------
    logic [7:0]            rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rx_wr_ptr;
    logic [DEPTH_LOG2-1:0] rx_rd_ptr;
    logic [DEPTH_LOG2:0]   rx_cnt;
    logic                  rx_is_full;
    logic                  rx_is_empty;
    logic                  rx_push;
    logic                  rx_pop;
    rx_state_t             rx_state;
    rx_state_t             rx_next;
    logic                  data_read_next;

    assign rx_is_full  = (rx_cnt == CNT_FULL);
    assign rx_is_empty = (rx_cnt == '0);
    assign rx_pop      = cpu_rd && !rx_is_empty && !fifo_clr;

    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else if (fifo_clr) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            rx_cnt    <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + CNT_ONE;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk_bus) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= rxdata;
    end

    // ---------------- RX FSM ----------------
    always_ff @(posedge clk_bus or negedge rst_n) begin
        if (!rst_n) begin
            rx_state  <= R_IDLE;
            data_read <= 1'b0;
        end else begin
            rx_state  <= rx_next;
            data_read <= data_read_next;
        end
    end

    // R_ACK waits for the uart to drop rxrecv so one frame yields one push.
    // When full, nothing is acknowledged: the uart keeps the byte and rts.
    always_comb begin
        rx_next        = rx_state;
        rx_push        = 1'b0;
        data_read_next = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rxrecv && !fifo_clr && (!rx_is_full || rx_pop)) begin
                    rx_push        = 1'b1;
                    data_read_next = 1'b1;
                    rx_next        = R_ACK;
                end
            end
            R_ACK: begin
                if (!rxrecv) rx_next = R_IDLE;
            end
            R_DROP:  rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    assign cpu_rdata    = rx_is_empty ? 8'h00 : rx_mem[rx_rd_ptr];
    assign rx_avail     = !rx_is_empty;
    assign rx_full      = rx_is_full;
    assign rx_count     = rx_cnt;
    assign rx_state_dbg = rx_state;

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge
//   Drives uart_fifo_bridge with directed and randomized traffic. A small
//   uart stand-in answers txbegin with a txbusy window and offers RX frames
//   through rxrecv/data_read. Expected TX and RX byte streams are kept in
//   queues and compared against what the bridge emits.

module tb_uart_fifo_bridge;

    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;

    logic           clk_bus = 1'b0;
    logic           rst_n = 1'b0;
    logic           fifo_clr = 1'b0;
    logic [7:0]     cpu_wdata = 8'h00;
    logic           cpu_wr = 1'b0;
    logic           cpu_rd = 1'b0;
    logic [7:0]     cpu_rdata;
    logic           rx_avail;
    logic           rx_full;
    logic           tx_full;
    logic           tx_empty;
    logic           tx_drop;
    logic [DL2:0]   rx_count;
    logic [7:0]     txdata;
    logic           txbegin;
    logic           txbusy = 1'b0;
    logic [7:0]     rxdata = 8'h00;
    logic           rxrecv = 1'b0;
    logic           data_read;
    logic [1:0]     tx_state_dbg;
    logic [1:0]     rx_state_dbg;

    uart_fifo_bridge #(.DEPTH_LOG2(DL2)) dut (
        .clk_bus      (clk_bus),
        .rst_n        (rst_n),
        .fifo_clr     (fifo_clr),
        .cpu_wdata    (cpu_wdata),
        .cpu_wr       (cpu_wr),
        .cpu_rd       (cpu_rd),
        .cpu_rdata    (cpu_rdata),
        .rx_avail     (rx_avail),
        .rx_full      (rx_full),
        .tx_full      (tx_full),
        .tx_empty     (tx_empty),
        .tx_drop      (tx_drop),
        .rx_count     (rx_count),
        .txdata       (txdata),
        .txbegin      (txbegin),
        .txbusy       (txbusy),
        .rxdata       (rxdata),
        .rxrecv       (rxrecv),
        .data_read    (data_read),
        .tx_state_dbg (tx_state_dbg),
        .rx_state_dbg (rx_state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_bus = ~clk_bus;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         total = 0;
    int         bad = 0;
    logic [7:0] tx_exp_q[$];
    logic [7:0] tx_seen_q[$];
    logic [7:0] rx_exp_q[$];
    int         tx_len = 4;
    int         launches = 0;
    int         launch_len = 0;
    int         dr_pulses = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- uart stand-in ----------------
    logic prev_txbegin = 1'b0;
    logic prev_dr = 1'b0;

    always @(negedge clk_bus) begin
        if (rst_n) begin
            if (txbegin) begin
                check("txbegin_single", prev_txbegin, 0);
                check("txbegin_while_busy", txbusy, 0);
                tx_seen_q.push_back(txdata);
                launch_len = tx_len;
                launches++;
            end
            if (data_read) begin
                check("data_read_single", prev_dr, 0);
                dr_pulses++;
            end
        end
        prev_txbegin = txbegin;
        prev_dr = data_read;
    end

    // txbusy rises the cycle after the uart samples txbegin and stays high
    // for launch_len cycles.
    int served = 0;
    int busy_left = 0;
    always @(posedge clk_bus) begin
        #1;
        if (launches != served) begin
            served = launches;
            busy_left = launch_len;
        end
        if (busy_left > 0) begin
            txbusy = 1'b1;
            busy_left--;
        end else begin
            txbusy = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_bus);
        #1;
    endtask

    task automatic cpu_write(input logic [7:0] b);
        cpu_wdata = b;
        cpu_wr = 1'b1;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic cpu_read();
        check("rd_head", cpu_rdata, (rx_exp_q.size() > 0) ? rx_exp_q[0] : 8'h00);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        if (rx_exp_q.size() > 0) void'(rx_exp_q.pop_front());
    endtask

    task automatic check_rx_state();
        check("rx_count", rx_count, rx_exp_q.size());
        check("rx_avail", rx_avail, rx_exp_q.size() > 0);
        check("rx_full", rx_full, rx_exp_q.size() == DEPTH);
        check("rx_head", cpu_rdata, (rx_exp_q.size() > 0) ? rx_exp_q[0] : 8'h00);
    endtask

    // Offer one frame; optionally pop the RX head in the same cycle.
    task automatic send_rx(input logic [7:0] b, input bit with_rd);
        bit got = 0;
        if (with_rd) begin
            check("rd_head", cpu_rdata, rx_exp_q[0]);
            void'(rx_exp_q.pop_front());
        end
        rxdata = b;
        rxrecv = 1'b1;
        cpu_rd = with_rd;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk_bus);
            got = data_read;
            @(posedge clk_bus);
            #1;
            cpu_rd = 1'b0;
        end
        check("rx_ack", got, 1);
        rxrecv = 1'b0;
        tick();
        rx_exp_q.push_back(b);
    endtask

    task automatic wait_tx_drain();
        bit done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk_bus);
            if (tx_empty && !txbusy) done = 1;
        end
        check("tx_drain", done, 1);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        bit         got;
        int         dr0;
        int         seen0;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_txbegin", txbegin, 0);
        check("rst_txdata", txdata, 8'h00);
        check("rst_data_read", data_read, 0);
        check("rst_tx_empty", tx_empty, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_tx_drop", tx_drop, 0);
        check_rx_state();

        // Single byte
        tx_len = 20;
        cpu_write(8'hA5);
        tx_exp_q.push_back(8'hA5);
        got = 0;
        for (int i = 0; i < 5 && !got; i++) begin
            @(negedge clk_bus);
            got = txbegin;
        end
        check("t1_txbegin", got, 1);
        check("t1_txdata", txdata, 8'hA5);
        @(negedge clk_bus);
        check("t1_txbegin_low", txbegin, 0);
        check("t1_tx_empty_busy", tx_empty, 0);
        wait_tx_drain();
        check("t1_tx_empty_done", tx_empty, 1);

        // Burst of 17 with the uart idle: one launches, 16 fill the FIFO
        tx_len = 60;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom);
            cpu_write(b);
            tx_exp_q.push_back(b);
        end
        check("t2_tx_full", tx_full, 1);
        check("t2_no_drop", tx_drop, 0);
        tx_len = 4;
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk_bus);
            got = !txbusy;
        end
        check("t2_busy_fall", got, 1);
        // Next cycle is the T_IDLE pop cycle: a write on full lands there
        tick();
        b = 8'($urandom);
        cpu_write(b);
        tx_exp_q.push_back(b);
        check("t2_full_push_pop", tx_full, 1);
        check("t2_full_push_nodrop", tx_drop, 0);
        cpu_write(8'h5A);
        check("t2_drop_set", tx_drop, 1);
        wait_tx_drain();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        check("t2_drop_cleared", tx_drop, 0);

        // RX: three frames, then pops
        dr0 = dr_pulses;
        send_rx(8'h41, 0);
        send_rx(8'h42, 0);
        send_rx(8'h43, 0);
        check("t3_dr_pulses", dr_pulses - dr0, 3);
        check("t3_rx_count", rx_count, 3);
        check("t3_head", cpu_rdata, 8'h41);
        repeat (3) cpu_read();
        check_rx_state();
        check("t3_empty_rdata", cpu_rdata, 8'h00);
        cpu_read();
        check_rx_state();

        // RX backpressure
        for (int i = 0; i < DEPTH; i++) send_rx(8'($urandom), 0);
        check("t4_rx_full", rx_full, 1);
        b = 8'($urandom);
        rxdata = b;
        rxrecv = 1'b1;
        dr0 = dr_pulses;
        repeat (20) @(negedge clk_bus);
        check("t4_no_ack_full", dr_pulses - dr0, 0);
        @(posedge clk_bus);
        #1;
        check("rd_head", cpu_rdata, rx_exp_q[0]);
        void'(rx_exp_q.pop_front());
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        got = 0;
        for (int i = 0; i < 2 && !got; i++) begin
            @(negedge clk_bus);
            got = data_read;
        end
        check("t4_ack_after_rd", got, 1);
        @(posedge clk_bus);
        #1;
        rxrecv = 1'b0;
        tick();
        rx_exp_q.push_back(b);
        check_rx_state();
        while (rx_exp_q.size() > 2) cpu_read();

        // RX push and pop in the same cycle
        send_rx(8'($urandom), 1);
        check("t5_rx_count_same", rx_count, 2);
        check_rx_state();

        // Flush while a TX byte is in flight
        tx_len = 30;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            cpu_write(b);
            tx_exp_q.push_back(b);
        end
        send_rx(8'($urandom), 0);
        repeat (2) tick();
        fifo_clr = 1'b1;
        tick();
        fifo_clr = 1'b0;
        rx_exp_q.delete();
        while (tx_exp_q.size() > tx_seen_q.size()) void'(tx_exp_q.pop_back());
        check("t6_tx_full_clr", tx_full, 0);
        check("t6_tx_inflight", tx_empty, 0);
        check_rx_state();
        wait_tx_drain();

        // Async reset mid T_WAIT and mid R_ACK
        tx_len = 40;
        cpu_write(8'h3C);
        tx_exp_q.push_back(8'h3C);
        rxdata = 8'h77;
        rxrecv = 1'b1;
        repeat (6) tick();
        rx_exp_q.push_back(8'h77);
        check_rx_state();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_txbegin", txbegin, 0);
        check("ar_txdata", txdata, 8'h00);
        check("ar_data_read", data_read, 0);
        check("ar_tx_empty", tx_empty, 1);
        check("ar_tx_drop", tx_drop, 0);
        rx_exp_q.delete();
        check_rx_state();
        rxrecv = 1'b0;
        @(negedge clk_bus);
        rst_n = 1'b1;
        seen0 = tx_seen_q.size();
        repeat (80) @(negedge clk_bus);
        check("ar_no_relaunch", tx_seen_q.size() - seen0, 0);
        tick();
        tx_len = 3;
        cpu_write(8'hC3);
        tx_exp_q.push_back(8'hC3);
        wait_tx_drain();

        // Randomized mix
        for (int it = 0; it < 150; it++) begin
            tx_len = $urandom_range(1, 6);
            case ($urandom_range(0, 3))
                0: begin
                    if (tx_exp_q.size() - tx_seen_q.size() < 12) begin
                        b = 8'($urandom);
                        cpu_write(b);
                        tx_exp_q.push_back(b);
                    end else begin
                        tick();
                    end
                end
                1: begin
                    if (rx_exp_q.size() < DEPTH)
                        send_rx(8'($urandom), (rx_exp_q.size() > 0) && ($urandom_range(0, 1) == 1));
                    else
                        cpu_read();
                end
                2: cpu_read();
                default: repeat ($urandom_range(1, 4)) tick();
            endcase
            check_rx_state();
        end
        wait_tx_drain();

        // TX stream comparison
        check("tx_frames", tx_seen_q.size(), tx_exp_q.size());
        for (int i = 0; i < tx_exp_q.size() && i < tx_seen_q.size(); i++)
            check("tx_byte", tx_seen_q[i], tx_exp_q[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
